layer_sequencer: RTL and testbench

- Per-sample scheduler for the conv1d network datapath.
- On each rising edge of sample_clk it runs this sequence:
  - clock the input left-shift buffers;
  - for each layer in order: reset/start its conv1d, wait for out_v, clock the activation cache that follows it;
  - latch the network output.
- Replaces the hand-written per-network state machine. Adds a run timeout, overrun detection and latency instrumentation.

---
 rtl/network_pkg.sv | 22 ++
 rtl/edge_detect.sv | 24 ++
 rtl/layer_sequencer.sv | 142 ++++++++++++++
 tb/tb_layer_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/network_pkg.sv
`default_nettype none
// ============================================================================
// Module   : network_pkg
// Purpose  : Shared sequencer state type and network-level defaults.
// Revision : 1.0 - initial release
// ============================================================================
package network_pkg;

  localparam int c_DEFAULT_N_LAYERS = 4;
  localparam int c_DEFAULT_TIMEOUT  = 1023;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_TICK_LSB   = 3'd1,
    ST_RST_CONV   = 3'd2,
    ST_RUN_CONV   = 3'd3,
    ST_TICK_CACHE = 3'd4,
    ST_LATCH_OUT  = 3'd5
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : edge_detect
// Purpose  : Registered rising-edge detector with async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_prev <= 1'b0;
    else      r_prev <= din;
  end

  assign rise = din & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer_sequencer
// Purpose  : Per-sample scheduler stepping the conv1d layers of the network.
// Revision : 1.0 - initial release
// ============================================================================
module layer_sequencer
  import network_pkg::*;
#(
  parameter int N_LAYERS = c_DEFAULT_N_LAYERS,
  parameter int TIMEOUT  = c_DEFAULT_TIMEOUT,
  parameter int CW       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_clk,
  input  logic [N_LAYERS-1:0]         conv_out_v,
  input  logic                        clear_flags,
  output logic                        lsb_tick,
  output logic [N_LAYERS-1:0]         conv_rst,
  output logic [N_LAYERS-2:0]         cache_tick,
  output logic                        out_latch,
  output logic                        busy,
  output logic [$clog2(N_LAYERS)-1:0] layer,
  output logic                        overrun,
  output logic                        timeout,
  output logic [CW-1:0]               overrun_cnt,
  output logic [CW-1:0]               cycles_last
);

  localparam int              c_LW      = $clog2(N_LAYERS);
  localparam int              c_RW      = $clog2(TIMEOUT + 1);
  localparam logic [c_LW-1:0] c_LAST    = c_LW'(N_LAYERS - 1);
  localparam logic [c_RW-1:0] c_TO_LAST = c_RW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   c_SAT     = '1;

  seq_state_t        r_state;
  seq_state_t        w_next;
  logic [c_LW-1:0]   r_layer;
  logic [c_RW-1:0]   r_run_cnt;
  logic [CW-1:0]     r_pass_cnt;
  logic [CW-1:0]     r_ovr_cnt;
  logic [CW-1:0]     r_cycles_last;
  logic              r_overrun;
  logic              r_timeout;
  logic              w_edge;
  logic              w_valid;
  logic              w_abort;
  logic              w_ovr;

  edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (sample_clk),
    .rise (w_edge)
  );

  // The first RUN_CONV cycle may still see the previous pass's valid.
  assign w_valid = (r_run_cnt != '0) && conv_out_v[r_layer];
  assign w_abort = (r_state == ST_RUN_CONV) && !w_valid && (r_run_cnt == c_TO_LAST);
  assign w_ovr   = w_edge && (r_state != ST_IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:       if (w_edge) w_next = ST_TICK_LSB;
      ST_TICK_LSB:   w_next = ST_RST_CONV;
      ST_RST_CONV:   w_next = ST_RUN_CONV;
      ST_RUN_CONV: begin
        if (w_valid)      w_next = (r_layer == c_LAST) ? ST_LATCH_OUT : ST_TICK_CACHE;
        else if (w_abort) w_next = ST_IDLE;
      end
      ST_TICK_CACHE: w_next = ST_RST_CONV;
      ST_LATCH_OUT:  w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_layer       <= '0;
      r_run_cnt     <= '0;
      r_pass_cnt    <= '0;
      r_cycles_last <= '0;
    end else begin
      r_state <= w_next;

      if (r_state == ST_TICK_LSB)        r_layer <= '0;
      else if (r_state == ST_TICK_CACHE) r_layer <= r_layer + 1'b1;

      if (r_state == ST_RST_CONV)        r_run_cnt <= '0;
      else if (r_state == ST_RUN_CONV)   r_run_cnt <= r_run_cnt + 1'b1;

      // Counts TICK_LSB as cycle 1 so LATCH_OUT reads the full pass length.
      if (r_state == ST_IDLE) begin
        if (w_edge) r_pass_cnt <= CW'(1);
      end else if (r_pass_cnt != c_SAT) begin
        r_pass_cnt <= r_pass_cnt + 1'b1;
      end

      if (r_state == ST_LATCH_OUT) r_cycles_last <= r_pass_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      r_ovr_cnt <= '0;
    end else if (clear_flags) begin
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      r_ovr_cnt <= '0;
    end else begin
      if (w_abort) r_timeout <= 1'b1;
      if (w_ovr) begin
        r_overrun <= 1'b1;
        if (r_ovr_cnt != c_SAT) r_ovr_cnt <= r_ovr_cnt + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < N_LAYERS; k++) begin : g_conv_rst
    assign conv_rst[k] = (r_state == ST_RST_CONV) && (r_layer == c_LW'(k));
  end

  for (genvar k = 0; k < N_LAYERS - 1; k++) begin : g_cache_tick
    assign cache_tick[k] = (r_state == ST_TICK_CACHE) && (r_layer == c_LW'(k));
  end

  assign lsb_tick    = (r_state == ST_TICK_LSB);
  assign out_latch   = (r_state == ST_LATCH_OUT);
  assign busy        = (r_state != ST_IDLE);
  assign layer       = r_layer;
  assign overrun     = r_overrun;
  assign timeout     = r_timeout;
  assign overrun_cnt = r_ovr_cnt;
  assign cycles_last = r_cycles_last;

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_sequencer
// Purpose  : Self-checking bench for layer_sequencer with a behavioural conv model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_sequencer;

  localparam int NL = 2;
  localparam int TO = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_clk = 1'b0;
  logic          clear_flags = 1'b0;
  logic [NL-1:0] conv_out_v;
  logic          lsb_tick, out_latch, busy, overrun, timeout;
  logic [NL-1:0] conv_rst;
  logic [NL-2:0] cache_tick;
  logic [0:0]    layer;
  logic [CW-1:0] overrun_cnt, cycles_last;

  int checks   = 0;
  int failures = 0;

  // Conv model: out_v rises 'lat' cycles after its reset pulse and stays high.
  int         since[NL];
  bit         armed[NL];
  int         lat[NL];
  bit         force0 = 1'b0;
  logic [6:0] exp_q[$];
  int         model_layer = 0;

  always #5 clk = ~clk;

  always_comb begin
    conv_out_v = '0;
    for (int k = 0; k < NL; k++) conv_out_v[k] = armed[k] && (since[k] >= lat[k]);
    if (force0) conv_out_v[0] = 1'b1;
  end

  layer_sequencer #(.N_LAYERS(NL), .TIMEOUT(TO), .CW(CW)) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk), .conv_out_v(conv_out_v),
    .clear_flags(clear_flags), .lsb_tick(lsb_tick), .conv_rst(conv_rst),
    .cache_tick(cache_tick), .out_latch(out_latch), .busy(busy), .layer(layer),
    .overrun(overrun), .timeout(timeout), .overrun_cnt(overrun_cnt),
    .cycles_last(cycles_last)
  );

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [6:0] obs();
    return {busy, layer, lsb_tick, conv_rst, cache_tick, out_latch};
  endfunction

  function automatic logic [6:0] idle_vec();
    return {1'b0, model_layer[0], 5'b0};
  endfunction

  task automatic tick();
    logic [NL-1:0] seen;
    seen = conv_rst;
    @(posedge clk);
    #1;
    for (int k = 0; k < NL; k++) begin
      if (seen[k]) begin
        since[k] = 1;
        armed[k] = 1'b1;
      end else if (since[k] < 100000) begin
        since[k]++;
      end
    end
  endtask

  task automatic start_pass();
    sample_clk = 1'b1;
    tick();
    sample_clk = 1'b0;
  endtask

  // Expected per-cycle output trace of one pass: {busy, layer, lsb, conv_rst, cache, latch}.
  task automatic build(input int l0, input int l1, output bit tmo);
    int l[NL];
    int runs;
    l[0] = l0; l[1] = l1; lat[0] = l0; lat[1] = l1;
    tmo = 1'b0;
    exp_q.delete();
    exp_q.push_back({1'b1, model_layer[0], 1'b1, 2'b00, 1'b0, 1'b0});
    for (int k = 0; k < NL; k++) begin
      model_layer = k;
      exp_q.push_back({1'b1, model_layer[0], 1'b0, 2'(1 << k), 1'b0, 1'b0});
      runs = max2(l[k], 2);
      if (runs > TO) begin
        repeat (TO) exp_q.push_back({1'b1, model_layer[0], 5'b0});
        tmo = 1'b1;
        return;
      end
      repeat (runs) exp_q.push_back({1'b1, model_layer[0], 5'b0});
      if (k < NL - 1) exp_q.push_back({1'b1, model_layer[0], 1'b0, 2'b00, 1'b1, 1'b0});
    end
    exp_q.push_back({1'b1, model_layer[0], 1'b0, 2'b00, 1'b0, 1'b1});
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs() !== 7'b0) begin failures++; $display("FAIL reset_async: got %b expected %b", obs(), 7'b0); end
    tick(); tick();
    checks++;
    if ({overrun, timeout, overrun_cnt, cycles_last} !== '0) begin
      failures++;
      $display("FAIL reset_flags: got ov=%b to=%b cnt=%0d cl=%0d expected all 0", overrun, timeout, overrun_cnt, cycles_last);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_pass_order();
    bit tmo;
    int nb = 0;
    build(3, 3, tmo);
    start_pass();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs() !== exp_q[i]) begin failures++; $display("FAIL order[%0d]: got %b expected %b", i, obs(), exp_q[i]); end
      if (busy) nb++;
      tick();
    end
    checks++;
    if (obs() !== idle_vec()) begin failures++; $display("FAIL order_idle: got %b expected %b", obs(), idle_vec()); end
    checks++;
    if (cycles_last !== 16'd11) begin failures++; $display("FAIL order_cycles_last: got %0d expected 11", cycles_last); end
    checks++;
    if (nb != 11) begin failures++; $display("FAIL order_busy_len: got %0d expected 11", nb); end
  endtask

  task automatic test_stale_valid();
    bit tmo;
    force0 = 1'b1;
    build(1, 3, tmo);
    start_pass();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs() !== exp_q[i]) begin failures++; $display("FAIL stale[%0d]: got %b expected %b", i, obs(), exp_q[i]); end
      tick();
    end
    force0 = 1'b0;
    checks++;
    if (cycles_last !== 16'd10) begin failures++; $display("FAIL stale_cycles_last: got %0d expected 10", cycles_last); end
  endtask

  task automatic test_timeout();
    bit tmo;
    build(3, 1000, tmo);
    start_pass();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs() !== exp_q[i]) begin failures++; $display("FAIL timeout[%0d]: got %b expected %b", i, obs(), exp_q[i]); end
      tick();
    end
    checks++;
    if (obs() !== idle_vec() || timeout !== tmo) begin
      failures++;
      $display("FAIL timeout_flag: got state=%b to=%b expected state=%b to=%b", obs(), timeout, idle_vec(), tmo);
    end
    checks++;
    if (cycles_last !== 16'd10) begin failures++; $display("FAIL timeout_cycles_kept: got %0d expected 10", cycles_last); end
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    checks++;
    if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_clear: got %b expected 0", timeout); end
  endtask

  task automatic test_overrun();
    bit tmo;
    build(3, 3, tmo);
    start_pass();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs() !== exp_q[i]) begin failures++; $display("FAIL overrun[%0d]: got %b expected %b", i, obs(), exp_q[i]); end
      sample_clk = (i == 2);
      tick();
    end
    sample_clk = 1'b0;
    checks++;
    if (overrun !== 1'b1 || overrun_cnt !== 16'd1) begin
      failures++;
      $display("FAIL overrun_flag: got ov=%b cnt=%0d expected ov=1 cnt=1", overrun, overrun_cnt);
    end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL overrun_no_second_pass: got busy=%b expected 0", busy); end
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    checks++;
    if (overrun !== 1'b0 || overrun_cnt !== 16'd0) begin
      failures++;
      $display("FAIL overrun_clear: got ov=%b cnt=%0d expected 0 0", overrun, overrun_cnt);
    end
    build(3, 3, tmo);
    start_pass();
    for (int i = 0; i < exp_q.size(); i++) begin
      sample_clk  = (i == 2);
      clear_flags = (i == 2);
      tick();
    end
    sample_clk = 1'b0;
    clear_flags = 1'b0;
    checks++;
    if (overrun !== 1'b0 || overrun_cnt !== 16'd0) begin
      failures++;
      $display("FAIL overrun_clear_wins: got ov=%b cnt=%0d expected 0 0", overrun, overrun_cnt);
    end
  endtask

  task automatic test_async_reset();
    bit tmo;
    build(5, 5, tmo);
    start_pass();
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (obs() !== exp_q[i]) begin failures++; $display("FAIL arst_pre[%0d]: got %b expected %b", i, obs(), exp_q[i]); end
      tick();
    end
    checks++;
    if (obs() !== exp_q[11]) begin failures++; $display("FAIL arst_in_run1: got %b expected %b", obs(), exp_q[11]); end
    #2 rst = 1'b0;
    #1;
    model_layer = 0;
    checks++;
    if (obs() !== 7'b0 || {overrun, timeout, overrun_cnt, cycles_last} !== '0) begin
      failures++;
      $display("FAIL arst_outputs: got %b cl=%0d expected all 0", obs(), cycles_last);
    end
    #2 rst = 1'b1;
    tick();
    build(3, 3, tmo);
    start_pass();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs() !== exp_q[i]) begin failures++; $display("FAIL arst_post[%0d]: got %b expected %b", i, obs(), exp_q[i]); end
      tick();
    end
    checks++;
    if (cycles_last !== 16'd11) begin failures++; $display("FAIL arst_post_cycles: got %0d expected 11", cycles_last); end
  endtask

  task automatic test_back_to_back();
    bit tmo;
    build(3, 3, tmo);
    start_pass();
    for (int i = 0; i < exp_q.size(); i++) tick();
    checks++;
    if (obs() !== idle_vec() || overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: got %b ov=%b expected %b ov=0", obs(), overrun, idle_vec());
    end
    start_pass();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs() !== exp_q[i]) begin failures++; $display("FAIL b2b_second[%0d]: got %b expected %b", i, obs(), exp_q[i]); end
      sample_clk = (i == exp_q.size() - 1);
      tick();
    end
    sample_clk = 1'b0;
    checks++;
    if (overrun !== 1'b1 || overrun_cnt !== 16'd1) begin
      failures++;
      $display("FAIL b2b_latch_overrun: got ov=%b cnt=%0d expected 1 1", overrun, overrun_cnt);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_dropped: got busy=%b expected 0", busy); end
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
  endtask

  task automatic test_random();
    bit tmo;
    int l0, l1;
    for (int n = 0; n < 8; n++) begin
      l0 = $urandom_range(1, 7);
      l1 = $urandom_range(1, 7);
      build(l0, l1, tmo);
      start_pass();
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs() !== exp_q[i]) begin failures++; $display("FAIL rand%0d[%0d]: got %b expected %b", n, i, obs(), exp_q[i]); end
        tick();
      end
      checks++;
      if (cycles_last !== CW'(5 + max2(l0, 2) + max2(l1, 2)) || overrun !== 1'b0 || timeout !== tmo) begin
        failures++;
        $display("FAIL rand%0d_result: got cl=%0d ov=%b to=%b expected cl=%0d ov=0 to=%b",
                 n, cycles_last, overrun, timeout, 5 + max2(l0, 2) + max2(l1, 2), tmo);
      end
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  initial begin
    for (int k = 0; k < NL; k++) begin since[k] = 0; armed[k] = 1'b0; lat[k] = 3; end
    test_reset();
    test_pass_order();
    test_stale_valid();
    test_timeout();
    test_overrun();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
